icache_ctrl: RTL and testbench

- Direct-mapped, read-only instruction cache; answers the fetch requests that the pipeline hazard logic raises.
- Fetch side: takes i_mem_read/i_address, returns i_data with i_ready (hit) and i_input_ready (line-fill done).
- Memory side: on a miss, fetches one whole line from backing memory with a req/ready handshake.
- Sits between the IF stage / hazard control and main memory.

---
 rtl/icache_ctrl.sv | 141 ++++++++++++++
 tb/tb_icache_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with whole-line fill from backing memory.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_ctrl #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_mem_read,
  input  logic [WORD_SIZE-1:0]            i_address,
  output logic [WORD_SIZE-1:0]            i_data,
  output logic                            i_ready,
  output logic                            i_input_ready,
  output logic                            mem_read,
  output logic [WORD_SIZE-1:0]            mem_address,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_data,
  input  logic                            mem_ready
`ifdef ICACHE_STATS_EN
  ,
  output logic [WORD_SIZE-1:0]            num_hit,
  output logic [WORD_SIZE-1:0]            num_miss
`endif
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = WORD_SIZE - OFF_BITS - IDX_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state_reg, state_next;

  logic [OFF_BITS-1:0] req_offset;
  logic [IDX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0] req_tag;

  logic [NUM_LINES-1:0]                     valid_reg;
  logic [TAG_BITS-1:0]                      tag_mem  [NUM_LINES];
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0]     data_mem [NUM_LINES];

  logic [TAG_BITS-1:0]  fill_tag_reg;
  logic [IDX_BITS-1:0]  fill_index_reg;
  logic                 input_ready_reg;
  logic [WORD_SIZE-1:0] hold_data_reg;

  logic                 hit;
  logic                 miss;
  logic                 fill_write;
  logic [WORD_SIZE-1:0] hit_word;

  assign req_offset = i_address[OFF_BITS-1:0];
  assign req_index  = i_address[OFF_BITS +: IDX_BITS];
  assign req_tag    = i_address[WORD_SIZE-1 -: TAG_BITS];

  // Lookup only happens in IDLE; during a fill the request is ignored entirely.
  assign hit        = (state_reg == IDLE) && i_mem_read && valid_reg[req_index] &&
                      (tag_mem[req_index] == req_tag);
  assign miss       = (state_reg == IDLE) && i_mem_read && !hit;
  assign hit_word   = data_mem[req_index][req_offset];
  assign fill_write = (state_reg == FILL) && mem_ready;

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill_write && (fill_index_reg == IDX_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (fill_write) begin
      tag_mem[fill_index_reg]  <= fill_tag_reg;
      data_mem[fill_index_reg] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      fill_tag_reg    <= '0;
      fill_index_reg  <= '0;
      input_ready_reg <= 1'b0;
      hold_data_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      input_ready_reg <= fill_write;
      if (miss) begin
        fill_tag_reg   <= req_tag;
        fill_index_reg <= req_index;
      end
      if (hit) begin
        hold_data_reg <= hit_word;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_read    = 1'b0;
    mem_address = '0;
    case (state_reg)
      IDLE: begin
        if (miss) state_next = FILL;
      end
      FILL: begin
        mem_read    = 1'b1;
        mem_address = {fill_tag_reg, fill_index_reg, {OFF_BITS{1'b0}}};
        if (mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign i_ready       = hit;
  assign i_data        = hit ? hit_word : hold_data_reg;
  assign i_input_ready = input_ready_reg;

`ifdef ICACHE_STATS_EN
  logic [WORD_SIZE-1:0] num_hit_reg;
  logic [WORD_SIZE-1:0] num_miss_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_hit_reg  <= '0;
      num_miss_reg <= '0;
    end else begin
      if (hit && (num_hit_reg != '1)) num_hit_reg <= num_hit_reg + 1'b1;
      if (miss && (num_miss_reg != '1)) num_miss_reg <= num_miss_reg + 1'b1;
    end
  end

  assign num_hit  = num_hit_reg;
  assign num_miss = num_miss_reg;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed cycle table, hand-written corner
// sequences, then random traffic against a line-directory reference model.
module tb_icache_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_mem_read;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_ready;
  logic        i_input_ready;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [63:0] mem_data;
  logic        mem_ready;
`ifdef ICACHE_STATS_EN
  logic [15:0] num_hit;
  logic [15:0] num_miss;
`endif

  icache_ctrl #(.WORD_SIZE(16), .LINE_WORDS(4), .NUM_LINES(4)) dut (
    .clk(clk), .reset(reset), .i_mem_read(i_mem_read), .i_address(i_address),
    .i_data(i_data), .i_ready(i_ready), .i_input_ready(i_input_ready),
    .mem_read(mem_read), .mem_address(mem_address), .mem_data(mem_data),
    .mem_ready(mem_ready)
`ifdef ICACHE_STATS_EN
    , .num_hit(num_hit), .num_miss(num_miss)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mword(input logic [15:0] a);
    return a * 16'd7 + 16'hC0DE;
  endfunction

  function automatic logic [63:0] mline(input logic [15:0] base);
    logic [63:0] l;
    for (int k = 0; k < 4; k++) l[16*k +: 16] = mword(base + 16'(k));
    return l;
  endfunction

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic        mrdy;
    logic        ir;
    logic [15:0] data;
    logic        iir;
    logic        mr;
    logic [15:0] ma;
  } vec_t;

  vec_t tbl [15];

  // Reference model state: which tag each line holds, plus fill bookkeeping.
  logic        mvalid [4];
  logic [11:0] mtag   [4];
  logic        in_fill;
  logic [15:0] fill_base;
  int          wait_cnt;
  logic        exp_iir;
  logic [15:0] last_data;
  int          nhits;
  int          nmiss;

  initial begin
    logic       hit;
    logic [1:0] idx;
    logic [11:0] tag;

    tbl[0]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004};
    tbl[2]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004};
    tbl[3]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004};
    tbl[4]  = '{1'b1, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004};
    tbl[5]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b0, 16'h0000};
    tbl[6]  = '{1'b1, 16'h0007, 1'b0, 1'b1, 16'hA003, 1'b0, 1'b0, 16'h0000};
    tbl[7]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 16'hA000, 1'b0, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 16'h0004, 1'b0, 1'b0, 16'hA000, 1'b0, 1'b0, 16'h0000};
    tbl[9]  = '{1'b0, 16'h0004, 1'b1, 1'b0, 16'hA000, 1'b0, 1'b0, 16'h0000};
    tbl[10] = '{1'b1, 16'h0015, 1'b0, 1'b0, 16'hA000, 1'b0, 1'b0, 16'h0000};
    tbl[11] = '{1'b1, 16'h0015, 1'b1, 1'b0, 16'hA000, 1'b0, 1'b1, 16'h0014};
    tbl[12] = '{1'b1, 16'h0015, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b0, 16'h0000};
    tbl[13] = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'hA001, 1'b0, 1'b0, 16'h0000};
    tbl[14] = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'hA001, 1'b0, 1'b1, 16'h0004};

    reset = 1'b1; i_mem_read = 1'b0; i_address = '0; mem_data = '0; mem_ready = 1'b0;
    #2;
    chk1("reset i_ready", i_ready, 1'b0);
    chk("reset i_data", i_data, 16'h0000);
    chk1("reset i_input_ready", i_input_ready, 1'b0);
    chk1("reset mem_read", mem_read, 1'b0);
    chk("reset mem_address", mem_address, 16'h0000);
    tick();
    tick();
    reset = 1'b0;

    // Cold miss, same-line hits, mem_ready ignored in IDLE, conflict eviction.
    mem_data = 64'hA003_A002_A001_A000;
    for (int i = 0; i < 15; i++) begin
      i_mem_read = tbl[i].rd; i_address = tbl[i].addr; mem_ready = tbl[i].mrdy;
      #2;
      chk1($sformatf("tbl%0d i_ready", i), i_ready, tbl[i].ir);
      chk($sformatf("tbl%0d i_data", i), i_data, tbl[i].data);
      chk1($sformatf("tbl%0d i_input_ready", i), i_input_ready, tbl[i].iir);
      chk1($sformatf("tbl%0d mem_read", i), mem_read, tbl[i].mr);
      if (tbl[i].mr) chk($sformatf("tbl%0d mem_address", i), mem_address, tbl[i].ma);
      tick();
    end
`ifdef ICACHE_STATS_EN
    chk("tbl num_miss", num_miss, 16'd3);
    chk("tbl num_hit", num_hit, 16'd4);
`endif

    // Reset in the middle of the 0x0004 fill.
    #2;
    reset = 1'b1;
    #1;
    chk1("rstfill mem_read", mem_read, 1'b0);
    chk("rstfill mem_address", mem_address, 16'h0000);
    chk1("rstfill i_ready", i_ready, 1'b0);
    chk("rstfill i_data", i_data, 16'h0000);
    chk1("rstfill i_input_ready", i_input_ready, 1'b0);
`ifdef ICACHE_STATS_EN
    chk("rstfill num_hit", num_hit, 16'd0);
    chk("rstfill num_miss", num_miss, 16'd0);
`endif
    tick();
    reset = 1'b0;
    i_mem_read = 1'b1; i_address = 16'h0015;
    #2;
    chk1("postrst miss i_ready", i_ready, 1'b0);
    tick();
    #2;
    chk1("postrst mem_read", mem_read, 1'b1);
    chk("postrst mem_address", mem_address, 16'h0014);
    mem_data = mline(16'h0014); mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;

    // Request dropped and redirected mid-fill; the fill still completes.
    i_mem_read = 1'b1; i_address = 16'h0020;
    #2;
    chk1("drop miss i_ready", i_ready, 1'b0);
    tick();
    #2;
    chk1("drop fill1 mem_read", mem_read, 1'b1);
    tick();
    i_mem_read = 1'b0; i_address = 16'h0015;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk1("drop hold mem_read", mem_read, 1'b1);
      chk("drop hold mem_address", mem_address, 16'h0020);
      chk1("drop hold i_ready", i_ready, 1'b0);
      tick();
    end
    mem_data = mline(16'h0020); mem_ready = 1'b1;
    #2;
    chk1("drop last mem_read", mem_read, 1'b1);
    tick();
    mem_ready = 1'b0; i_mem_read = 1'b1; i_address = 16'h0015;
    #2;
    chk1("drop after i_ready", i_ready, 1'b1);
    chk("drop after i_data", i_data, mword(16'h0015));
    chk1("drop after i_input_ready", i_input_ready, 1'b1);
    tick();
    i_address = 16'h0023;
    #2;
    chk1("drop line i_ready", i_ready, 1'b1);
    chk("drop line i_data", i_data, mword(16'h0023));
    chk1("drop line mem_read", mem_read, 1'b0);
    tick();

    // Random traffic against the reference model, from a clean reset.
    i_mem_read = 1'b0; mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int l = 0; l < 4; l++) begin mvalid[l] = 1'b0; mtag[l] = '0; end
    in_fill = 1'b0; fill_base = '0; wait_cnt = 0; exp_iir = 1'b0;
    last_data = '0; nhits = 0; nmiss = 0;
    for (int c = 0; c < 400; c++) begin
      i_mem_read = ($urandom_range(0, 3) != 0);
      i_address  = 16'($urandom_range(0, 63));
      if (in_fill) begin
        mem_ready = (wait_cnt == 0);
        mem_data  = mline(fill_base);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_data  = {$urandom, $urandom};
      end
      #2;
      idx = i_address[3:2];
      tag = i_address[15:4];
      hit = !in_fill && i_mem_read && mvalid[idx] && (mtag[idx] == tag);
      chk1("rnd i_ready", i_ready, hit);
      chk("rnd i_data", i_data, hit ? mword(i_address) : last_data);
      chk1("rnd i_input_ready", i_input_ready, exp_iir);
      chk1("rnd mem_read", mem_read, in_fill);
      if (in_fill) chk("rnd mem_address", mem_address, fill_base);
      exp_iir = 1'b0;
      if (in_fill) begin
        if (wait_cnt == 0) begin
          mvalid[fill_base[3:2]] = 1'b1;
          mtag[fill_base[3:2]]   = fill_base[15:4];
          in_fill = 1'b0;
          exp_iir = 1'b1;
        end else begin
          wait_cnt--;
        end
      end else if (i_mem_read) begin
        if (hit) begin
          last_data = mword(i_address);
          nhits++;
        end else begin
          in_fill   = 1'b1;
          fill_base = i_address & 16'hFFFC;
          wait_cnt  = $urandom_range(0, 3);
          nmiss++;
        end
      end
      tick();
    end
`ifdef ICACHE_STATS_EN
    chk("rnd num_hit", num_hit, 16'(nhits));
    chk("rnd num_miss", num_miss, 16'(nmiss));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
